pipeline_hazard_ctrl: RTL and testbench

- Hazard/issue controller for the 5-stage pipeline: F, D, E, M, W.
- Mirrors the destination-register state of the E, M and W stages in an internal in-flight table.
- Each cycle it decides whether the decoded instruction issues, stalls or is flushed, and generates forwarding selects for the execute operands.
- Sits beside decode and drives the stall/flush enables of the fetch, decode and execute pipeline registers. Its only inputs are decode control outputs, the execute redirect and the memory ready handshake.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/issue controller:
// forwarding select encodings, in-flight entry attributes and FSM states.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int REG_BITS_DEF = 5;
  localparam int CNT_BITS_DEF = 16;

  // Per-entry attributes; the valid bit and rd travel alongside as vld_pN / rd_pN.
  typedef struct packed {
    logic wen;
    logic ld;
    logic mem;
  } entry_attr_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/execute/memory side signals of the hazard controller, grouped so the
// pipeline (master) and controller (slave) share one bundle.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs1;
  logic [REG_BITS-1:0] id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [REG_BITS-1:0] id_rd;
  logic                id_wEn;
  logic                id_is_load;
  logic                id_is_mem;
  logic                ex_redirect;
  logic                mem_ready;
  logic                stall_fetch;
  logic                stall_decode;
  logic                flush_decode;
  logic                bubble_execute;
  logic [1:0]          fwd_a_sel;
  logic [1:0]          fwd_b_sel;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wEn,
           id_is_load, id_is_mem, ex_redirect, mem_ready,
    input  stall_fetch, stall_decode, flush_decode, bubble_execute,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wEn,
           id_is_load, id_is_mem, ex_redirect, mem_ready,
    output stall_fetch, stall_decode, flush_decode, bubble_execute,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one source register: nearest producing stage
// wins (E, then M, then W); a load in E cannot forward and x0 never forwards.
module pipeline_hazard_ctrl_fwd_select
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] rs,
  input  logic                vld_e,
  input  logic                wen_e,
  input  logic                ld_e,
  input  logic [REG_BITS-1:0] rd_e,
  input  logic                vld_m,
  input  logic                wen_m,
  input  logic [REG_BITS-1:0] rd_m,
  input  logic                vld_w,
  input  logic                wen_w,
  input  logic [REG_BITS-1:0] rd_w,
  output logic [1:0]          sel
);
  logic hit_e, hit_m, hit_w;

  assign hit_e = vld_e & wen_e & ~ld_e & (rd_e != '0) & (rd_e == rs);
  assign hit_m = vld_m & wen_m & (rd_m != '0) & (rd_m == rs);
  assign hit_w = vld_w & wen_w & (rd_w != '0) & (rd_w == rs);

  always_comb begin
    sel = FWD_RF;
    if (hit_e)      sel = FWD_EX;
    else if (hit_m) sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/issue controller for the F/D/E/M/W pipeline: tracks E/M/W destination
// state, decides issue/stall/flush for decode and drives forwarding selects.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);
  logic                vld_p0, vld_p1, vld_p2;
  logic [REG_BITS-1:0] rd_p0, rd_p1, rd_p2;
  entry_attr_t         attr_p0;
  logic                wen_p1, mem_p1, wen_p2;
  state_t              state, state_nxt;
  logic                mem_wait, lu_hazard, redirect, lu_rs1, lu_rs2;
  logic                stall, flush, bubble, advance, insert;
  logic [CNT_BITS-1:0] stall_cnt_q, flush_cnt_q;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign mem_wait  = vld_p1 & mem_p1 & ~bus.mem_ready;
  assign redirect  = bus.ex_redirect & vld_p0;
  assign lu_rs1    = bus.id_use_rs1 & (bus.id_rs1 == rd_p0);
  assign lu_rs2    = bus.id_use_rs2 & (bus.id_rs2 == rd_p0);
  assign lu_hazard = bus.id_valid & vld_p0 & attr_p0.ld & attr_p0.wen &
                     (rd_p0 != '0) & (lu_rs1 | lu_rs2);

  // A frozen table keeps E intact, so a redirect seen during MEM_HOLD is simply
  // re-evaluated on the cycle the memory access completes.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;
    advance   = 1'b0;
    insert    = 1'b0;
    if (reset) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:      if (mem_wait) state_nxt = MEM_HOLD;
        MEM_HOLD: if (bus.mem_ready) state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
      if (mem_wait) begin
        stall = 1'b1;
      end else if (redirect) begin
        flush   = 1'b1;
        bubble  = 1'b1;
        advance = 1'b1;
      end else if (lu_hazard) begin
        stall   = 1'b1;
        bubble  = 1'b1;
        advance = 1'b1;
      end else begin
        advance = 1'b1;
        insert  = 1'b1;
      end
    end
  end

  // Control: valid bits, FSM and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        vld_p0 <= insert & bus.id_valid;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  // Data: D -> E (p0) -> M (p1) -> W (p2)
  always_ff @(posedge clock) begin
    if (advance) begin
      rd_p0   <= bus.id_rd;
      attr_p0 <= '{wen: bus.id_wEn, ld: bus.id_is_load, mem: bus.id_is_mem};
      rd_p1   <= rd_p0;
      wen_p1  <= attr_p0.wen;
      mem_p1  <= attr_p0.mem;
      rd_p2   <= rd_p1;
      wen_p2  <= wen_p1;
    end
  end

  pipeline_hazard_ctrl_fwd_select #(.REG_BITS(REG_BITS)) u_fwd_a (
    .rs(bus.id_rs1),
    .vld_e(vld_p0), .wen_e(attr_p0.wen), .ld_e(attr_p0.ld), .rd_e(rd_p0),
    .vld_m(vld_p1), .wen_m(wen_p1), .rd_m(rd_p1),
    .vld_w(vld_p2), .wen_w(wen_p2), .rd_w(rd_p2),
    .sel(bus.fwd_a_sel)
  );

  pipeline_hazard_ctrl_fwd_select #(.REG_BITS(REG_BITS)) u_fwd_b (
    .rs(bus.id_rs2),
    .vld_e(vld_p0), .wen_e(attr_p0.wen), .ld_e(attr_p0.ld), .rd_e(rd_p0),
    .vld_m(vld_p1), .wen_m(wen_p1), .rd_m(rd_p1),
    .vld_w(vld_p2), .wen_w(wen_p2), .rd_w(rd_p2),
    .sel(bus.fwd_b_sel)
  );

  assign bus.stall_fetch    = stall;
  assign bus.stall_decode   = stall;
  assign bus.flush_decode   = flush;
  assign bus.bubble_execute = bubble;
  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.flush_cnt      = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of per-cycle vectors with
// hand-computed outputs, then counter saturation sequences (4-bit counters).
module tb_pipeline_hazard_ctrl;
  localparam int RB = 5;
  localparam int CB = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.REG_BITS(RB), .CNT_BITS(CB)) bus ();

  pipeline_hazard_ctrl #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct {
    logic          rst, v;
    logic [RB-1:0] rs1, rs2, rd;
    logic          u1, u2, wen, ld, mem, redir, mrdy;
    logic          sf, sd, fl, bu;
    logic [1:0]    fa, fb;
    int            sc, fc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic v,
                     input int rs1, input logic u1, input int rs2, input logic u2,
                     input int rd, input logic wen, input logic ld, input logic mem,
                     input logic redir, input logic mrdy,
                     input logic sf, input logic sd, input logic fl, input logic bu,
                     input int fa, input int fb, input int sc, input int fc);
    vec_t t;
    t.rst = rst; t.v = v; t.rs1 = RB'(rs1); t.u1 = u1; t.rs2 = RB'(rs2); t.u2 = u2;
    t.rd = RB'(rd); t.wen = wen; t.ld = ld; t.mem = mem; t.redir = redir; t.mrdy = mrdy;
    t.sf = sf; t.sd = sd; t.fl = fl; t.bu = bu; t.fa = 2'(fa); t.fb = 2'(fb);
    t.sc = sc; t.fc = fc;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                       input logic u2, input int rd, input logic wen, input logic ld,
                       input logic mem, input logic redir, input logic mrdy);
    bus.id_valid = v; bus.id_rs1 = RB'(rs1); bus.id_use_rs1 = u1;
    bus.id_rs2 = RB'(rs2); bus.id_use_rs2 = u2; bus.id_rd = RB'(rd);
    bus.id_wEn = wen; bus.id_is_load = ld; bus.id_is_mem = mem;
    bus.ex_redirect = redir; bus.mem_ready = mrdy;
  endtask

  initial begin
    //   rst v  rs1 u1 rs2 u2 rd wen ld mem rdr mrdy  sf sd fl bu fa fb sc fc
    add(1, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0, 0, 0); // reset state
    add(0, 1,  1, 1,  2, 1,  5, 1, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0, 0, 0); // add x5
    add(0, 1,  5, 1,  3, 1,  7, 1, 0, 0,  0, 1,   0, 0, 0, 0, 1, 0, 0, 0); // sub rs1=x5 -> EX
    add(0, 1,  5, 1,  0, 0,  6, 1, 1, 1,  0, 1,   0, 0, 0, 0, 2, 0, 0, 0); // lw x6
    add(0, 1,  5, 1,  6, 1,  8, 1, 0, 0,  0, 1,   1, 1, 0, 1, 3, 0, 0, 0); // load-use stall
    add(0, 1,  5, 1,  6, 1,  8, 1, 0, 0,  0, 1,   0, 0, 0, 0, 0, 2, 1, 0); // retry: fwd_b MEM
    add(0, 1,  8, 1,  6, 1,  0, 1, 0, 0,  0, 1,   0, 0, 0, 0, 1, 3, 1, 0); // writes x0; W load fwd
    add(0, 1,  0, 1,  8, 1,  9, 1, 0, 0,  0, 1,   0, 0, 0, 0, 0, 2, 1, 0); // reads x0 -> RF
    add(0, 1,  9, 1,  0, 0, 10, 1, 1, 1,  0, 1,   0, 0, 0, 0, 1, 0, 1, 0); // lw x10
    add(0, 1, 10, 1,  0, 0, 11, 1, 0, 0,  1, 1,   0, 0, 1, 1, 0, 0, 1, 0); // redirect beats load-use
    add(0, 1, 10, 1,  0, 0, 11, 1, 0, 0,  0, 0,   1, 1, 0, 0, 2, 0, 1, 1); // mem wait 1
    add(0, 1, 10, 1,  0, 0, 11, 1, 0, 0,  0, 0,   1, 1, 0, 0, 2, 0, 2, 1); // mem wait 2
    add(0, 1, 10, 1,  0, 0, 11, 1, 0, 0,  0, 0,   1, 1, 0, 0, 2, 0, 3, 1); // mem wait 3
    add(0, 1, 10, 1,  0, 0, 11, 1, 0, 0,  0, 1,   0, 0, 0, 0, 2, 0, 4, 1); // mem done, issue
    add(0, 1, 11, 1,  0, 0, 12, 1, 1, 1,  0, 1,   0, 0, 0, 0, 1, 0, 4, 1); // lw x12
    add(0, 1, 12, 1, 11, 1,  0, 0, 0, 1,  0, 1,   1, 1, 0, 1, 0, 2, 4, 1); // sw: load-use on rs1
    add(0, 1, 12, 1, 11, 1,  0, 0, 0, 1,  0, 1,   0, 0, 0, 0, 2, 3, 5, 1); // sw issues
    add(0, 1,  0, 0,  0, 0,  0, 0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0, 5, 1); // beq
    add(0, 1,  0, 1,  0, 0, 13, 1, 0, 0,  1, 0,   1, 1, 0, 0, 0, 0, 5, 1); // redirect held by mem wait
    add(0, 1,  0, 1,  0, 0, 13, 1, 0, 0,  1, 1,   0, 0, 1, 1, 0, 0, 6, 1); // redirect re-evaluated
    add(0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 6, 2); // non-mem M, no wait
    add(0, 1,  0, 0,  0, 0, 14, 1, 1, 1,  0, 1,   0, 0, 0, 0, 0, 0, 6, 2); // lw x14
    add(0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0, 6, 2);
    add(0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 0, 6, 2); // mem wait
    add(1, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 7, 2); // reset mid-stall
    add(0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  1, 0,   0, 0, 0, 0, 0, 0, 0, 0); // no residual stall

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst;
      drive(vq[i].v, int'(vq[i].rs1), vq[i].u1, int'(vq[i].rs2), vq[i].u2, int'(vq[i].rd),
            vq[i].wen, vq[i].ld, vq[i].mem, vq[i].redir, vq[i].mrdy);
      @(negedge clock);
      chk($sformatf("v%0d.stall_fetch", i),    int'(bus.stall_fetch),    int'(vq[i].sf));
      chk($sformatf("v%0d.stall_decode", i),   int'(bus.stall_decode),   int'(vq[i].sd));
      chk($sformatf("v%0d.flush_decode", i),   int'(bus.flush_decode),   int'(vq[i].fl));
      chk($sformatf("v%0d.bubble_execute", i), int'(bus.bubble_execute), int'(vq[i].bu));
      chk($sformatf("v%0d.fwd_a_sel", i),      int'(bus.fwd_a_sel),      int'(vq[i].fa));
      chk($sformatf("v%0d.fwd_b_sel", i),      int'(bus.fwd_b_sel),      int'(vq[i].fb));
      chk($sformatf("v%0d.stall_cnt", i),      int'(bus.stall_cnt),      vq[i].sc);
      chk($sformatf("v%0d.flush_cnt", i),      int'(bus.flush_cnt),      vq[i].fc);
      @(posedge clock);
      #1;
    end

    // Stall counter saturation: lw held in M for 17 cycles
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clock); #1;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      if (k >= 14) chk($sformatf("sat.stall_cnt.k%0d", k), int'(bus.stall_cnt), (k > 15) ? 15 : k);
      if (k == 16) chk("sat.stall_decode", int'(bus.stall_decode), 1);
      @(posedge clock); #1;
    end
    bus.mem_ready = 1'b1;
    @(negedge clock);
    chk("sat.stall_cnt.final", int'(bus.stall_cnt), 15);
    chk("sat.stall_released", int'(bus.stall_decode), 0);
    @(posedge clock); #1;

    // Flush counter saturation: 17 redirects
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clock); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clock);
      if (i == 15) chk("sat.flush_cnt.i15", int'(bus.flush_cnt), 15);
      if (i == 16) chk("sat.flush_decode", int'(bus.flush_decode), 1);
      @(posedge clock); #1;
    end
    bus.ex_redirect = 1'b0;
    @(negedge clock);
    chk("sat.flush_cnt.final", int'(bus.flush_cnt), 15);
    chk("sat.stall_cnt.kept", int'(bus.stall_cnt), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
